fp_packer_pipe: RTL and testbench

- Output end of the FPU add path: takes the unpacked adder result (sign, biased exponent, unnormalised 57-bit significand, special-value flags).
- Normalises, rounds per RM, detects overflow/underflow, packs to IEEE-754 double, or single in the low word.
- 3-stage valid/ready pipeline between the adder and the result writeback.

---
 rtl/fpu_pkg.sv | 55 +++++
 rtl/fp_round_incr.sv | 26 ++
 rtl/fp_packer_pipe.sv | 276 +++++++++++++++++++++++++++
 tb/tb_fp_packer_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, result kinds, format limits, special
// encodings, flag bit positions and a leading-zero counter used by normalisation.
package fpu_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef enum logic [1:0] {
    K_NORM = 2'b00,
    K_ZERO = 2'b01,
    K_INF  = 2'b10,
    K_NAN  = 2'b11
  } kind_e;

  localparam logic [10:0] BIAS_D = 11'd1023;
  localparam logic [10:0] BIAS_S = 11'd127;

  // First biased exponent that no longer fits the target format.
  localparam logic [11:0] EXP_OVF_D = 12'd2047;
  localparam logic [11:0] EXP_OVF_S = 12'd255;

  localparam logic [63:0] QNAN_D_C = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] QNAN_S_C = 32'h7FC0_0000;
  localparam logic [63:0] INF_D    = 64'h7FF0_0000_0000_0000;
  localparam logic [31:0] INF_S    = 32'h7F80_0000;
  localparam logic [63:0] MAXF_D   = 64'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [31:0] MAXF_S   = 32'h7F7F_FFFF;

  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  // Number of zeros above the most significant one; 56 for an all-zero input.
  function automatic logic [5:0] lzc56(input logic [55:0] v);
    logic [5:0] n;
    logic       hit;
    n   = 6'd0;
    hit = 1'b0;
    for (int i = 55; i >= 0; i--) begin
      if (v[i]) begin
        hit = 1'b1;
      end else if (!hit) begin
        n = n + 6'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_round_incr.sv
// Round-increment decision from rounding mode, sign, lsb and guard/round/sticky.
// Purely combinational so the adder and multiplier paths can share it.
module fp_round_incr
  import fpu_pkg::*;
(
  input  logic [1:0] rm_i,
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       g_i,
  input  logic       r_i,
  input  logic       s_i,
  output logic       incr_o
);

  always_comb begin
    incr_o = 1'b0;
    case (rm_e'(rm_i))
      RM_RNE:  incr_o = g_i & (r_i | s_i | lsb_i);
      RM_RZ:   incr_o = 1'b0;
      RM_RUP:  incr_o = ~sign_i & (g_i | r_i | s_i);
      RM_RDN:  incr_o = sign_i & (g_i | r_i | s_i);
      default: incr_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_packer_pipe.sv
// Three-stage normalise / round / pack pipeline for the FPU add path (IEEE double,
// or single in the low word). Optional sticky flag accumulator: PACKER_STICKY_FLAGS_EN.
module fp_packer_pipe
  import fpu_pkg::*;
#(
  parameter int          LZW    = 6,
  parameter logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000,
  parameter logic [31:0] QNAN_S = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        ss,
  input  logic [10:0] es,
  input  logic [56:0] fs,
  input  logic        sp_zero,
  input  logic        sp_inf,
  input  logic        sp_nan,
  input  logic        db,
  input  logic [1:0]  RM,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [2:0]  out_flags
`ifdef PACKER_STICKY_FLAGS_EN
  ,
  input  logic        flags_clr,
  output logic [2:0]  sticky_flags
`endif
);

  logic           rdy_q;
  logic           s1_v_q, s2_v_q, s3_v_q;
  logic           s1_adv_s, s2_adv_s, s3_adv_s;

  logic [5:0]     lz_s;
  logic [10:0]    es_m1_s;
  logic [LZW-1:0] sh_s;
  logic [55:0]    shl_s;
  logic [55:0]    s1_man_d, s1_man_q;
  logic [11:0]    s1_exp_d, s1_exp_q;
  logic           s1_sign_d, s1_sign_q;
  kind_e          s1_kind_d, s1_kind_q;
  logic           s1_db_q;
  rm_e            s1_rm_q;

  logic           r_lsb_s, r_g_s, r_r_s, r_s_s, r_inc_s;
  logic [53:0]    sum_d_s;
  logic [24:0]    sum_s_s;
  logic           carry_s, hid_s;
  logic [51:0]    s2_frac_d, s2_frac_q;
  logic [11:0]    s2_exp_d, s2_exp_q;
  logic           s2_inx_d, s2_inx_q;
  logic           s2_sign_q, s2_db_q;
  kind_e          s2_kind_q;
  rm_e            s2_rm_q;

  logic           ovf_s, to_inf_s;
  logic [63:0]    s3_data_d, s3_data_q;
  logic [2:0]     s3_flags_d, s3_flags_q;

  // Each stage moves when it is empty or the stage after it moves.
  assign s3_adv_s  = ~s3_v_q | out_ready;
  assign s2_adv_s  = ~s2_v_q | s3_adv_s;
  assign s1_adv_s  = ~s1_v_q | s2_adv_s;
  assign in_ready  = rdy_q & s1_adv_s;
  assign out_valid = s3_v_q;
  assign out_data  = s3_data_q;
  assign out_flags = s3_flags_q;

  // Left shift never drives the exponent below 1; leftover leading zeros mean denormal.
  always_comb begin
    lz_s     = lzc56(fs[55:0]);
    es_m1_s  = es - 11'd1;
    sh_s     = ({5'd0, lz_s} <= es_m1_s) ? LZW'(lz_s) : LZW'(es_m1_s);
    shl_s    = fs[55:0] << sh_s;
    s1_man_d = shl_s;
    s1_exp_d = 12'd0;
    if (fs[56]) begin
      s1_man_d = {fs[56:2], fs[1] | fs[0]};
      s1_exp_d = {1'b0, es} + 12'd1;
    end else if (shl_s[55]) begin
      s1_exp_d = {1'b0, es} - {{(12-LZW){1'b0}}, sh_s};
    end else begin
      s1_exp_d = 12'd0;
    end

    s1_sign_d = ss;
    s1_kind_d = K_NORM;
    if (sp_nan) begin
      s1_kind_d = K_NAN;
    end else if (sp_inf) begin
      s1_kind_d = K_INF;
    end else if (sp_zero) begin
      s1_kind_d = K_ZERO;
    end else if (fs == 57'd0) begin
      s1_kind_d = K_ZERO;
      s1_sign_d = ss | (RM == 2'b11);
    end else begin
      s1_kind_d = K_NORM;
    end
  end

  always_comb begin
    if (s1_db_q) begin
      r_lsb_s = s1_man_q[3];
      r_g_s   = s1_man_q[2];
      r_r_s   = s1_man_q[1];
      r_s_s   = s1_man_q[0];
    end else begin
      r_lsb_s = s1_man_q[32];
      r_g_s   = s1_man_q[31];
      r_r_s   = 1'b0;
      r_s_s   = |s1_man_q[30:0];
    end
  end

  fp_round_incr u_round_incr (
    .rm_i   (s1_rm_q),
    .sign_i (s1_sign_q),
    .lsb_i  (r_lsb_s),
    .g_i    (r_g_s),
    .r_i    (r_r_s),
    .s_i    (r_s_s),
    .incr_o (r_inc_s)
  );

  // Mantissa carry-out bumps the exponent; a denormal rounding up to 1.0 becomes exponent 1.
  always_comb begin
    sum_d_s = {1'b0, s1_man_q[55:3]} + {53'd0, r_inc_s};
    sum_s_s = {1'b0, s1_man_q[55:32]} + {24'd0, r_inc_s};
    if (s1_db_q) begin
      carry_s   = sum_d_s[53];
      hid_s     = sum_d_s[52];
      s2_frac_d = carry_s ? 52'd0 : sum_d_s[51:0];
    end else begin
      carry_s   = sum_s_s[24];
      hid_s     = sum_s_s[23];
      s2_frac_d = {29'd0, (carry_s ? 23'd0 : sum_s_s[22:0])};
    end
    s2_exp_d = s1_exp_q + {11'd0, carry_s} + {11'd0, (s1_exp_q == 12'd0) & hid_s};
    s2_inx_d = r_g_s | r_r_s | r_s_s;
  end

  always_comb begin
    s3_data_d  = 64'd0;
    s3_flags_d = 3'd0;
    ovf_s      = s2_db_q ? (s2_exp_q >= EXP_OVF_D) : (s2_exp_q >= EXP_OVF_S);
    to_inf_s   = (s2_rm_q == RM_RNE) | ((s2_rm_q == RM_RUP) & ~s2_sign_q) |
                 ((s2_rm_q == RM_RDN) & s2_sign_q);
    case (s2_kind_q)
      K_NAN: begin
        s3_data_d = s2_db_q ? QNAN_D : {32'd0, QNAN_S};
      end
      K_INF: begin
        s3_data_d = s2_db_q ? {s2_sign_q, INF_D[62:0]} : {32'd0, s2_sign_q, INF_S[30:0]};
      end
      K_ZERO: begin
        s3_data_d = s2_db_q ? {s2_sign_q, 63'd0} : {32'd0, s2_sign_q, 31'd0};
      end
      K_NORM: begin
        if (ovf_s) begin
          if (s2_db_q) begin
            s3_data_d = {s2_sign_q, (to_inf_s ? INF_D[62:0] : MAXF_D[62:0])};
          end else begin
            s3_data_d = {32'd0, s2_sign_q, (to_inf_s ? INF_S[30:0] : MAXF_S[30:0])};
          end
          s3_flags_d[FLG_OVF] = 1'b1;
          s3_flags_d[FLG_INX] = 1'b1;
        end else begin
          if (s2_db_q) begin
            s3_data_d = {s2_sign_q, s2_exp_q[10:0], s2_frac_q};
          end else begin
            s3_data_d = {32'd0, s2_sign_q, s2_exp_q[7:0], s2_frac_q[22:0]};
          end
          s3_flags_d[FLG_UNF] = (s2_exp_q == 12'd0) & s2_inx_q;
          s3_flags_d[FLG_INX] = s2_inx_q;
        end
      end
      default: begin
        s3_data_d  = 64'd0;
        s3_flags_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_man_q  <= 56'd0;
      s1_exp_q  <= 12'd0;
      s1_sign_q <= 1'b0;
      s1_kind_q <= K_NORM;
      s1_db_q   <= 1'b0;
      s1_rm_q   <= RM_RNE;
    end else begin
      rdy_q <= 1'b1;
      if (s1_adv_s) begin
        s1_v_q <= in_valid & in_ready;
      end
      if (s1_adv_s & in_valid & in_ready) begin
        s1_man_q  <= s1_man_d;
        s1_exp_q  <= s1_exp_d;
        s1_sign_q <= s1_sign_d;
        s1_kind_q <= s1_kind_d;
        s1_db_q   <= db;
        s1_rm_q   <= rm_e'(RM);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_frac_q <= 52'd0;
      s2_exp_q  <= 12'd0;
      s2_inx_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_db_q   <= 1'b0;
      s2_kind_q <= K_NORM;
      s2_rm_q   <= RM_RNE;
    end else begin
      if (s2_adv_s) begin
        s2_v_q <= s1_v_q;
      end
      if (s2_adv_s & s1_v_q) begin
        s2_frac_q <= s2_frac_d;
        s2_exp_q  <= s2_exp_d;
        s2_inx_q  <= s2_inx_d;
        s2_sign_q <= s1_sign_q;
        s2_db_q   <= s1_db_q;
        s2_kind_q <= s1_kind_q;
        s2_rm_q   <= s1_rm_q;
      end
    end
  end

  // Output register only reloads on advance, so a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v_q     <= 1'b0;
      s3_data_q  <= 64'd0;
      s3_flags_q <= 3'd0;
    end else begin
      if (s3_adv_s) begin
        s3_v_q <= s2_v_q;
      end
      if (s3_adv_s & s2_v_q) begin
        s3_data_q  <= s3_data_d;
        s3_flags_q <= s3_flags_d;
      end
    end
  end

`ifdef PACKER_STICKY_FLAGS_EN
  logic [2:0] sticky_q;

  // Clear takes effect first so a same-cycle handshake still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 3'd0;
    end else if (flags_clr) begin
      sticky_q <= (out_valid & out_ready) ? s3_flags_q : 3'd0;
    end else if (out_valid & out_ready) begin
      sticky_q <= sticky_q | s3_flags_q;
    end else begin
      sticky_q <= sticky_q;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_packer_pipe.sv
// Directed self-checking bench for fp_packer_pipe: rounding/overflow/denormal/special
// vectors, latency, backpressure and mid-flight reset.
module tb_fp_packer_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        ss;
  logic [10:0] es;
  logic [56:0] fs;
  logic        sp_zero, sp_inf, sp_nan;
  logic        db;
  logic [1:0]  RM;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_flags;
`ifdef PACKER_STICKY_FLAGS_EN
  logic        flags_clr;
  logic [2:0]  sticky_flags;
`endif

  int n_tests;
  int n_fail;

  fp_packer_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ss        (ss),
    .es        (es),
    .fs        (fs),
    .sp_zero   (sp_zero),
    .sp_inf    (sp_inf),
    .sp_nan    (sp_nan),
    .db        (db),
    .RM        (RM),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
`ifdef PACKER_STICKY_FLAGS_EN
    ,
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_beat(input logic s, input logic [10:0] e, input logic [56:0] f,
                          input logic d, input logic [1:0] rm, input logic [2:0] sp);
    ss = s; es = e; fs = f; db = d; RM = rm;
    {sp_nan, sp_inf, sp_zero} = sp;
    in_valid = 1'b1;
  endtask

  // Called at a falling edge with an empty pipe; sends one beat, checks latency and result.
  task automatic send_and_check(input string tag, input logic s, input logic [10:0] e,
                                input logic [56:0] f, input logic d, input logic [1:0] rm,
                                input logic [2:0] sp, input logic [63:0] xd, input logic [2:0] xf);
    int lat;
    bit got;
    out_ready = 1'b1;
    set_beat(s, e, f, d, rm, sp);
    #1;
    check_eq($sformatf("%s_in_ready", tag), 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (out_valid) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
    end
    check_eq($sformatf("%s_latency", tag), 64'(lat), 64'd3);
    check_eq($sformatf("%s_data", tag), out_data, xd);
    check_eq($sformatf("%s_flags", tag), 64'(out_flags), 64'(xf));
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] bp_exp(input int i);
    return {1'b0, 11'h3FF + 11'(i), 52'd0};
  endfunction

  initial begin
    int acc;
    int rx;
    int used;
    int seen;
    logic [63:0] held;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    ss = 1'b0; es = 11'd1; fs = 57'd0; db = 1'b1; RM = 2'b00;
    sp_zero = 1'b0; sp_inf = 1'b0; sp_nan = 1'b0;
`ifdef PACKER_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_out_flags", 64'(out_flags), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready_early", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rel_in_ready_after", 64'(in_ready), 64'd1);

    send_and_check("3p3", 1'b0, 11'h400, 57'h180_0000_0000_0000, 1'b1, 2'b00, 3'b000,
                   64'h4018_0000_0000_0000, 3'b000);
    send_and_check("ovf_rne", 1'b0, 11'h7FE, 57'h100_0000_0000_0000, 1'b1, 2'b00, 3'b000,
                   64'h7FF0_0000_0000_0000, 3'b101);
    send_and_check("ovf_rz", 1'b0, 11'h7FE, 57'h100_0000_0000_0000, 1'b1, 2'b01, 3'b000,
                   64'h7FEF_FFFF_FFFF_FFFF, 3'b101);
    send_and_check("ovf_rup_neg", 1'b1, 11'h7FE, 57'h100_0000_0000_0000, 1'b1, 2'b10, 3'b000,
                   64'hFFEF_FFFF_FFFF_FFFF, 3'b101);
    send_and_check("ovf_rdn_neg", 1'b1, 11'h7FE, 57'h100_0000_0000_0000, 1'b1, 2'b11, 3'b000,
                   64'hFFF0_0000_0000_0000, 3'b101);
    send_and_check("tie_even", 1'b0, 11'h3FF, 57'h080_0000_0000_0004, 1'b1, 2'b00, 3'b000,
                   64'h3FF0_0000_0000_0000, 3'b001);
    send_and_check("tie_odd", 1'b0, 11'h3FF, 57'h080_0000_0000_000C, 1'b1, 2'b00, 3'b000,
                   64'h3FF0_0000_0000_0002, 3'b001);
    send_and_check("tie_carry", 1'b0, 11'h3FF, 57'h0FF_FFFF_FFFF_FFFC, 1'b1, 2'b00, 3'b000,
                   64'h4000_0000_0000_0000, 3'b001);
    send_and_check("rup_sticky", 1'b0, 11'h3FF, 57'h080_0000_0000_0001, 1'b1, 2'b10, 3'b000,
                   64'h3FF0_0000_0000_0001, 3'b001);
    send_and_check("rz_sticky", 1'b0, 11'h3FF, 57'h080_0000_0000_0001, 1'b1, 2'b01, 3'b000,
                   64'h3FF0_0000_0000_0000, 3'b001);
    send_and_check("norm_left", 1'b0, 11'h400, 57'h020_0000_0000_0000, 1'b1, 2'b00, 3'b000,
                   64'h3FE0_0000_0000_0000, 3'b000);
    send_and_check("dbl_denorm", 1'b0, 11'h003, 57'h004_0000_0000_0000, 1'b1, 2'b00, 3'b000,
                   64'h0002_0000_0000_0000, 3'b000);
    send_and_check("sgl_norm", 1'b0, 11'h07F, 57'h0C0_0000_0000_0000, 1'b0, 2'b00, 3'b000,
                   64'h0000_0000_3FC0_0000, 3'b000);
    send_and_check("sgl_denorm", 1'b0, 11'h001, 57'h040_0000_0000_0000, 1'b0, 2'b00, 3'b000,
                   64'h0000_0000_0040_0000, 3'b000);
    send_and_check("sgl_denorm_inx", 1'b0, 11'h001, 57'h040_0000_8000_0000, 1'b0, 2'b00, 3'b000,
                   64'h0000_0000_0040_0000, 3'b011);
    send_and_check("nan_sgl", 1'b0, 11'h07F, 57'h080_0000_0000_0000, 1'b0, 2'b00, 3'b111,
                   64'h0000_0000_7FC0_0000, 3'b000);
    send_and_check("inf_neg_dbl", 1'b1, 11'h3FF, 57'h080_0000_0000_0000, 1'b1, 2'b00, 3'b010,
                   64'hFFF0_0000_0000_0000, 3'b000);
    send_and_check("zero_cancel_rdn", 1'b0, 11'h3FF, 57'd0, 1'b1, 2'b11, 3'b000,
                   64'h8000_0000_0000_0000, 3'b000);
    send_and_check("zero_cancel_rne", 1'b0, 11'h3FF, 57'd0, 1'b1, 2'b00, 3'b000,
                   64'h0000_0000_0000_0000, 3'b000);

    // Backpressure: six stalled cycles with beats offered.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 5) set_beat(1'b0, 11'h3FF + 11'(acc), 57'h080_0000_0000_0000, 1'b1, 2'b00, 3'b000);
      #1;
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check_eq("bp_accepted", 64'(acc), 64'd3);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    check_eq("bp_out_valid", 64'(out_valid), 64'd1);
    held = out_data;
    check_eq("bp_head_data", held, bp_exp(0));
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_hold_stable", out_data, held);
    out_ready = 1'b1;
    rx = 0;
    used = 0;
    for (int c = 0; c < 20 && rx < 5; c++) begin
      if (acc < 5) begin
        set_beat(1'b0, 11'h3FF + 11'(acc), 57'h080_0000_0000_0000, 1'b1, 2'b00, 3'b000);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        check_eq($sformatf("bp_drain_%0d", rx), out_data, bp_exp(rx));
        rx++;
      end
      used++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("bp_drain_count", 64'(rx), 64'd5);
    check_eq("bp_drain_cycles", 64'(used), 64'd5);

    // Mid-flight reset: fill the pipe, then pulse rst_n between clock edges.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_beat(1'b0, 11'h400, 57'h080_0000_0000_0000, 1'b1, 2'b00, 3'b000);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check_eq("mid_pre_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_out_data", out_data, 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("mid_rst_no_emit", 64'(seen), 64'd0);
    check_eq("mid_rst_in_ready_back", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
